mem_responder: RTL and testbench
================================

# mem_responder

Single-port memory responder that serves the pipeline's `imem_*` / `dmem_*` request interface from the memory side. It accepts one request at a time, defined by address, byte read mask, byte write mask and write data. It returns a one-cycle `resp` pulse with read data after a programmable latency, and can optionally add pseudo-random extra delay to exercise the core's freeze logic. One instance backs the instruction port and one backs the data port in the core-level bench and in the FPGA top.

## Interface
- `DEPTH_LOG2`, 12: array depth is 2^DEPTH_LOG2 32-bit words.
- `BASE_ADDR`, 32'h0000_0000: byte address of word 0; must be word-aligned.
- `LATENCY`, 2: cycles from accept to `resp`; legal range 1..15.
- `RAND_EXTRA`, 0: when 1, add 0..3 extra cycles per request, taken from an LFSR.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `mem_addr` in 32: byte address; bits [1:0] ignored.
- `mem_rmask` in 4: byte read enables; any nonzero bit marks a read request.
- `mem_wmask` in 4: byte write enables; any nonzero bit marks a write request.
- `mem_wdata` in 32: write data, byte lanes aligned to `mem_wmask`.
- `mem_rdata` out 32: read data; valid only while `mem_resp`=1, otherwise 0.
- `mem_resp` out 1: one-cycle completion pulse.
- `mem_err` out 1: pulses together with `mem_resp` when the request was illegal.

## Operation
- FSM states:
  - IDLE: `mem_rmask|mem_wmask` nonzero at a rising edge → accept and go to WAIT.
  - WAIT: count down; at zero go to RESP.
  - RESP: drive `resp`; go to IDLE.
- On accept, capture the request:
  - Word index = (`mem_addr` − BASE_ADDR) >> 2.
  - In range = index < 2^DEPTH_LOG2 (unsigned compare on the full 32-bit difference).
- Write (wmask≠0, rmask=0, in range): at the accept edge, write each byte lane i where wmask[i]=1; other lanes are unchanged.
- Read (rmask≠0, wmask=0, in range): at the accept edge, copy the full word into the hold register. Bytes with rmask=0 are still returned; the initiator extracts the lanes it needs.
- Illegal requests return `mem_rdata`=0 with `mem_err`=1 and never touch the array. Illegal means either:
  - rmask≠0 and wmask≠0 together, or
  - address out of range.
- Write response: `mem_rdata`=0, `mem_err`=0.
- Requests seen in WAIT or RESP are ignored. The initiator holds its request stable until `resp`, so the held copy is not re-accepted. The next request is accepted no earlier than the cycle after RESP.
- LFSR (RAND_EXTRA=1):
  - 8-bit Fibonacci, taps 8,6,5,4; seed 8'hA5 on reset.
  - Advances once per accept.
  - Extra delay = lfsr[1:0], sampled at accept.
- Array contents are not cleared by `rst`. Contents are X/uninitialised until written; the bench preloads through hierarchical access.

## Timing
- Accept at edge of cycle T → `mem_resp`=1 in cycle T+LATENCY+extra, exactly one cycle wide.
- LATENCY=1, extra=0: `resp` in cycle T+1.
- Throughput: at most one request per LATENCY+extra+1 cycles.
- Writes are visible to any later accepted read, including a read accepted in the cycle right after RESP.
- `mem_rdata` and `mem_err` are registered; they change only at edges and are 0 whenever `mem_resp`=0.
- Reset values:
  - FSM = IDLE, counter = 0, `mem_resp`=0, `mem_rdata`=0, `mem_err`=0, LFSR = 8'hA5.
- `rst` asserted in WAIT or RESP:
  - The pending response is dropped, and no `resp` is issued after reset.
  - A write already committed at accept stays in the array.
- `rst` together with a valid request at the same edge: reset wins and the request is not accepted.

## Test plan
- Preload word 0x10 = 32'hDEADBEEF, LATENCY=2. Read at addr 0x40, rmask 4'hF, held until `resp` → `resp` exactly 2 cycles after accept, `rdata`=32'hDEADBEEF, `err`=0, one-cycle pulse.
- Write 32'h11223344 to 0x40 with wmask 4'b0101, then read 0x40 → `rdata`=32'hDE22BE44.
- Requests with rmask=4'hF and wmask=4'h1 together, then a read at BASE_ADDR+4·2^DEPTH_LOG2 → both give `resp` with `err`=1 and `rdata`=0; the array is unchanged.
- Back-to-back reads held continuously, LATENCY=1 → `resp` every 2 cycles, with no duplicate accept of a held request.
- Assert `rst` in the WAIT cycle after accepting a read → no `resp` for 20 cycles. The next request after reset completes normally.
- RAND_EXTRA=1, 64 reads → every latency lies in LATENCY..LATENCY+3. The sequence of extras matches the reference LFSR model from seed 8'hA5.

Source files
------------

// File: rtl/mem_responder.sv
// mem_responder: single-port word memory that answers one request at a time
// on the pipeline's imem/dmem request interface.
//
// A request is presented as address + byte read mask + byte write mask + write
// data and is held stable by the initiator until mem_resp_o. It is accepted
// in IDLE. The array is written, or read into a hold register, at the accept
// edge. A one-cycle mem_resp_o pulse follows LATENCY (+0..3 pseudo-random
// extra) cycles later. Requests that are out of range, or that set both a read
// and a write mask, complete with mem_err_o=1 and never touch the array.
//
// Parameters:
//   DEPTH_LOG2 - array holds 2^DEPTH_LOG2 32-bit words (legal up to 29)
//   BASE_ADDR  - word-aligned byte address of word 0
//   LATENCY    - cycles from request cycle to response cycle, 1..15
//   RAND_EXTRA - 1: add lfsr[1:0] extra cycles per request
//
// Ports:
//   clk_i        - clock, rising edge
//   rst_i        - synchronous active-high reset; array contents are kept
//   mem_addr_i   - byte address, bits [1:0] ignored
//   mem_rmask_i  - byte read enables (nonzero = read request)
//   mem_wmask_i  - byte write enables (nonzero = write request)
//   mem_wdata_i  - write data, byte lanes aligned to mem_wmask_i
//   mem_rdata_o  - read data, valid with mem_resp_o, 0 otherwise
//   mem_resp_o   - one-cycle completion pulse
//   mem_err_o    - illegal-request flag, pulses together with mem_resp_o
module mem_responder #(
    parameter int          DEPTH_LOG2 = 12,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          LATENCY    = 2,
    parameter int          RAND_EXTRA = 0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] mem_addr_i,
    input  logic [3:0]  mem_rmask_i,
    input  logic [3:0]  mem_wmask_i,
    input  logic [31:0] mem_wdata_i,
    output logic [31:0] mem_rdata_o,
    output logic        mem_resp_o,
    output logic        mem_err_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam int WORDS = 1 << DEPTH_LOG2;

    logic [31:0] mem_q [0:WORDS-1];

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [7:0]  lfsr_q, lfsr_d;
    logic [31:0] hold_q, hold_d;
    logic        herr_q, herr_d;
    logic [31:0] rdata_q, rdata_d;
    logic        resp_q, resp_d;
    logic        err_q, err_d;

    logic [31:0]           offs_s;
    logic [31:0]           word_s;
    logic [DEPTH_LOG2-1:0] idx_s;
    logic                  in_range_s;
    logic                  is_rd_s;
    logic                  is_wr_s;
    logic                  illegal_s;
    logic                  accept_s;
    logic                  do_write_s;
    logic [1:0]            extra_s;
    logic [4:0]            delay_s;
    logic                  lfsr_fb_s;

    // Address decode: the subtraction wraps, so addresses below BASE_ADDR
    // land far above the array and are rejected by the range compare.
    assign offs_s     = mem_addr_i - BASE_ADDR;
    assign word_s     = offs_s >> 2;
    assign idx_s      = word_s[DEPTH_LOG2-1:0];
    assign in_range_s = (word_s < (32'd1 << DEPTH_LOG2));
    assign is_rd_s    = |mem_rmask_i;
    assign is_wr_s    = |mem_wmask_i;
    assign illegal_s  = (is_rd_s && is_wr_s) || !in_range_s;

    // Reset outranks a request presented at the same edge.
    assign accept_s   = (state_q == S_IDLE) && (is_rd_s || is_wr_s) && !rst_i;
    assign do_write_s = accept_s && is_wr_s && !illegal_s;

    // Fibonacci LFSR, taps 8,6,5,4 -> bits 7,5,4,3, shifting toward the MSB.
    assign lfsr_fb_s = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
    assign extra_s   = (RAND_EXTRA != 0) ? lfsr_q[1:0] : 2'd0;
    // Cycles spent in WAIT; zero means the response follows the accept edge.
    assign delay_s   = 5'(LATENCY) + {3'd0, extra_s} - 5'd1;

    // Next-state, hold capture and registered output values.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lfsr_d  = lfsr_q;
        hold_d  = hold_q;
        herr_d  = herr_q;
        resp_d  = 1'b0;
        rdata_d = 32'd0;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (is_rd_s || is_wr_s) begin
                    lfsr_d = {lfsr_q[6:0], lfsr_fb_s};
                    herr_d = illegal_s;
                    if (is_rd_s && !illegal_s) begin
                        hold_d = mem_q[idx_s];
                    end else begin
                        hold_d = 32'd0;
                    end
                    cnt_d = delay_s;
                    if (delay_s == 5'd0) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (cnt_q <= 5'd1) begin
                    cnt_d   = 5'd0;
                    state_d = S_RESP;
                end else begin
                    cnt_d   = cnt_q - 5'd1;
                    state_d = S_WAIT;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 5'd0;
            end
        endcase
        // Outputs are loaded on the edge that enters RESP, so they are
        // nonzero exactly during the RESP cycle.
        if (state_d == S_RESP) begin
            resp_d  = 1'b1;
            rdata_d = hold_d;
            err_d   = herr_d;
        end else begin
            resp_d  = 1'b0;
        end
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= 5'd0;
            lfsr_q  <= 8'hA5;
            hold_q  <= 32'd0;
            herr_q  <= 1'b0;
            resp_q  <= 1'b0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lfsr_q  <= lfsr_d;
            hold_q  <= hold_d;
            herr_q  <= herr_d;
            resp_q  <= resp_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Byte-lane writes at the accept edge; the array is never reset.
    always_ff @(posedge clk_i) begin
        if (do_write_s) begin
            for (int i = 0; i < 4; i++) begin
                if (mem_wmask_i[i]) begin
                    mem_q[idx_s][8*i +: 8] <= mem_wdata_i[8*i +: 8];
                end
            end
        end
    end

    assign mem_rdata_o = rdata_q;
    assign mem_resp_o  = resp_q;
    assign mem_err_o   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder. Three instances share one clock:
//   0: LATENCY=2, no random delay (directed, illegal, random, reset tests)
//   1: LATENCY=1, no random delay (back-to-back tests)
//   2: LATENCY=2, RAND_EXTRA=1 (LFSR delay test)
// Latency is counted in cycles from the cycle the request is first presented
// (accepted at its closing edge) to the cycle mem_resp is high.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        rst   [3];
    logic [31:0] addr  [3];
    logic [3:0]  rm    [3];
    logic [3:0]  wm    [3];
    logic [31:0] wdata [3];
    logic [31:0] rdata [3];
    logic        resp  [3];
    logic        err   [3];

    logic [31:0] model0 [4096];
    logic [31:0] model1 [16];
    logic [31:0] model2 [64];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mem_responder #(
            .DEPTH_LOG2(12),
            .BASE_ADDR (32'h0000_0000),
            .LATENCY   ((g == 1) ? 1 : 2),
            .RAND_EXTRA((g == 2) ? 1 : 0)
        ) dut (
            .clk_i      (clk),
            .rst_i      (rst[g]),
            .mem_addr_i (addr[g]),
            .mem_rmask_i(rm[g]),
            .mem_wmask_i(wm[g]),
            .mem_wdata_i(wdata[g]),
            .mem_rdata_o(rdata[g]),
            .mem_resp_o (resp[g]),
            .mem_err_o  (err[g])
        );
    end

    // Present one request to instance k, hold it until resp, then drop it.
    // Returns latency (-1 on timeout), data, err and resp one cycle later.
    task automatic do_req(input int k, input logic [31:0] a, input logic [3:0] r,
                          input logic [3:0] w, input logic [31:0] d,
                          output int lat, output logic [31:0] rd,
                          output logic e, output logic after);
        @(negedge clk);
        addr[k] = a; rm[k] = r; wm[k] = w; wdata[k] = d;
        lat = -1; rd = 32'd0; e = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (resp[k] === 1'b1) begin
                lat = n; rd = rdata[k]; e = err[k];
                break;
            end
        end
        rm[k] = 4'd0; wm[k] = 4'd0;
        @(posedge clk); #1;
        after = resp[k];
    endtask

    // Reference byte-lane merge.
    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] m);
        logic [31:0] res;
        res = old;
        for (int i = 0; i < 4; i++) if (m[i]) res[8*i +: 8] = d[8*i +: 8];
        return res;
    endfunction

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b1; addr[k] = 32'd0; rm[k] = 4'd0; wm[k] = 4'd0; wdata[k] = 32'd0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            total++;
            if (resp[k] !== 1'b0 || rdata[k] !== 32'd0 || err[k] !== 1'b0) begin
                bad++;
                $display("FAIL reset_outputs inst=%0d resp=%b rdata=%h err=%b required 0/0/0",
                         k, resp[k], rdata[k], err[k]);
            end
        end
        @(negedge clk);
        for (int k = 0; k < 3; k++) rst[k] = 1'b0;
    endtask

    task automatic test_directed();
        int lat; logic [31:0] rd; logic e, af;
        do_req(0, 32'h40, 4'hF, 4'h0, 32'd0, lat, rd, e, af);
        total++;
        if (lat !== 2 || rd !== 32'hDEADBEEF || e !== 1'b0 || af !== 1'b0) begin
            bad++;
            $display("FAIL read_preload lat=%0d rdata=%h err=%b after=%b required 2/deadbeef/0/0",
                     lat, rd, e, af);
        end
        do_req(0, 32'h40, 4'h0, 4'b0101, 32'h11223344, lat, rd, e, af);
        model0[16] = merge(model0[16], 32'h11223344, 4'b0101);
        total++;
        if (lat !== 2 || rd !== 32'd0 || e !== 1'b0 || af !== 1'b0) begin
            bad++;
            $display("FAIL write_resp lat=%0d rdata=%h err=%b after=%b required 2/0/0/0",
                     lat, rd, e, af);
        end
        do_req(0, 32'h40, 4'h1, 4'h0, 32'd0, lat, rd, e, af);
        total++;
        if (lat !== 2 || rd !== 32'hDE22BE44 || e !== 1'b0) begin
            bad++;
            $display("FAIL read_after_write lat=%0d rdata=%h err=%b required 2/de22be44/0",
                     lat, rd, e);
        end
    endtask

    task automatic test_illegal();
        int lat; logic [31:0] rd; logic e, af;
        do_req(0, 32'h40, 4'hF, 4'h1, 32'hFFFF_FFFF, lat, rd, e, af);
        total++;
        if (lat !== 2 || rd !== 32'd0 || e !== 1'b1 || af !== 1'b0) begin
            bad++;
            $display("FAIL illegal_both lat=%0d rdata=%h err=%b after=%b required 2/0/1/0",
                     lat, rd, e, af);
        end
        do_req(0, 32'h4000, 4'hF, 4'h0, 32'd0, lat, rd, e, af);
        total++;
        if (lat !== 2 || rd !== 32'd0 || e !== 1'b1) begin
            bad++;
            $display("FAIL out_of_range lat=%0d rdata=%h err=%b required 2/0/1", lat, rd, e);
        end
        do_req(0, 32'h40, 4'hF, 4'h0, 32'd0, lat, rd, e, af);
        total++;
        if (rd !== model0[16] || e !== 1'b0) begin
            bad++;
            $display("FAIL illegal_no_write rdata=%h err=%b required %h/0", rd, e, model0[16]);
        end
    endtask

    task automatic test_random();
        int lat, kind, idx; logic [31:0] rd, a, d, exp_rd; logic [3:0] r, w;
        logic e, af, exp_e;
        for (int i = 0; i < 60; i++) begin
            kind = int'($urandom_range(0, 3));
            idx  = int'($urandom_range(0, 31));
            a    = 32'(idx * 4) | 32'($urandom_range(0, 3));
            d    = $urandom;
            r    = 4'd0; w = 4'd0;
            exp_rd = 32'd0; exp_e = 1'b0;
            case (kind)
                0: begin r = 4'($urandom_range(1, 15)); exp_rd = model0[idx]; end
                1: begin w = 4'($urandom_range(1, 15)); model0[idx] = merge(model0[idx], d, w); end
                2: begin r = 4'($urandom_range(1, 15)); w = 4'($urandom_range(1, 15)); exp_e = 1'b1; end
                default: begin
                    a = 32'h4000 + 32'($urandom_range(0, 32'h7FFF_0000));
                    if ($urandom_range(0, 1) == 0) r = 4'hF; else w = 4'hF;
                    exp_e = 1'b1;
                end
            endcase
            do_req(0, a, r, w, d, lat, rd, e, af);
            total++;
            if (lat !== 2 || rd !== exp_rd || e !== exp_e || af !== 1'b0) begin
                bad++;
                $display("FAIL random_op i=%0d kind=%0d addr=%h lat=%0d rdata=%h err=%b after=%b required 2/%h/%b/0",
                         i, kind, a, lat, rd, e, af, exp_rd, exp_e);
            end
        end
    endtask

    task automatic test_back_to_back();
        int pulses; logic [31:0] newv;
        // Read held continuously: pulse every other cycle, outputs 0 between.
        @(negedge clk);
        addr[1] = 32'h14; rm[1] = 4'hF; wm[1] = 4'h0;
        pulses = 0;
        for (int n = 1; n <= 10; n++) begin
            @(posedge clk); #1;
            total++;
            if ((n % 2) == 1) begin
                if (resp[1] !== 1'b1 || rdata[1] !== model1[5] || err[1] !== 1'b0) begin
                    bad++;
                    $display("FAIL b2b_pulse n=%0d resp=%b rdata=%h err=%b required 1/%h/0",
                             n, resp[1], rdata[1], err[1], model1[5]);
                end
            end else begin
                if (resp[1] !== 1'b0 || rdata[1] !== 32'd0 || err[1] !== 1'b0) begin
                    bad++;
                    $display("FAIL b2b_gap n=%0d resp=%b rdata=%h err=%b required 0/0/0",
                             n, resp[1], rdata[1], err[1]);
                end
            end
        end
        rm[1] = 4'd0;
        @(posedge clk); #1;
        // Write, then a read presented during RESP: accepted right after RESP.
        newv = $urandom;
        @(negedge clk);
        addr[1] = 32'h18; wm[1] = 4'hF; wdata[1] = newv;
        @(posedge clk); #1;
        model1[6] = newv;
        total++;
        if (resp[1] !== 1'b1 || err[1] !== 1'b0) begin
            bad++;
            $display("FAIL b2b_write resp=%b err=%b required 1/0", resp[1], err[1]);
        end
        wm[1] = 4'h0; rm[1] = 4'hF;
        pulses = 0;
        @(posedge clk); #1;
        pulses += (resp[1] === 1'b1) ? 1 : 0;
        @(posedge clk); #1;
        total++;
        if (pulses != 0 || resp[1] !== 1'b1 || rdata[1] !== model1[6]) begin
            bad++;
            $display("FAIL b2b_read_after_write early=%0d resp=%b rdata=%h required 0/1/%h",
                     pulses, resp[1], rdata[1], model1[6]);
        end
        rm[1] = 4'd0;
        @(posedge clk); #1;
    endtask

    task automatic test_rst_wait();
        int cnt, lat; logic [31:0] rd, d; logic e, af;
        // Reset during WAIT of a read drops the response.
        @(negedge clk);
        addr[0] = 32'h40; rm[0] = 4'hF;
        @(posedge clk); #1;
        @(negedge clk); rst[0] = 1'b1; rm[0] = 4'd0;
        @(negedge clk); rst[0] = 1'b0;
        cnt = 0;
        repeat (20) begin @(posedge clk); #1; if (resp[0] !== 1'b0) cnt++; end
        total++;
        if (cnt != 0) begin
            bad++;
            $display("FAIL rst_wait_no_resp resp_cycles=%0d required 0", cnt);
        end
        // Write accepted, then reset in WAIT: data stays committed.
        d = $urandom;
        @(negedge clk);
        addr[0] = 32'h48; wm[0] = 4'hF; wdata[0] = d;
        @(posedge clk); #1;
        model0[18] = d;
        @(negedge clk); rst[0] = 1'b1; wm[0] = 4'd0;
        @(negedge clk); rst[0] = 1'b0;
        // Write presented together with reset is not accepted.
        @(negedge clk);
        rst[0] = 1'b1; addr[0] = 32'h44; wm[0] = 4'hF; wdata[0] = ~model0[17];
        @(negedge clk); rst[0] = 1'b0; wm[0] = 4'd0;
        cnt = 0;
        repeat (5) begin @(posedge clk); #1; if (resp[0] !== 1'b0) cnt++; end
        total++;
        if (cnt != 0) begin
            bad++;
            $display("FAIL rst_with_req_no_resp resp_cycles=%0d required 0", cnt);
        end
        do_req(0, 32'h40, 4'hF, 4'h0, 32'd0, lat, rd, e, af);
        total++;
        if (lat !== 2 || rd !== model0[16] || e !== 1'b0 || af !== 1'b0) begin
            bad++;
            $display("FAIL after_rst_read lat=%0d rdata=%h err=%b required 2/%h/0", lat, rd, e, model0[16]);
        end
        do_req(0, 32'h48, 4'hF, 4'h0, 32'd0, lat, rd, e, af);
        total++;
        if (rd !== model0[18]) begin
            bad++;
            $display("FAIL committed_write_kept rdata=%h required %h", rd, model0[18]);
        end
        do_req(0, 32'h44, 4'hF, 4'h0, 32'd0, lat, rd, e, af);
        total++;
        if (rd !== model0[17]) begin
            bad++;
            $display("FAIL rst_blocks_write rdata=%h required %h", rd, model0[17]);
        end
    endtask

    task automatic test_lfsr();
        int lat, idx, exp_lat; logic [31:0] rd; logic e, af;
        logic [7:0] lf; logic fb;
        lf = 8'hA5;
        for (int i = 0; i < 64; i++) begin
            exp_lat = 2 + int'(lf) % 4;
            fb = ^(lf & 8'hB8);
            lf = 8'(((int'(lf) * 2) + int'(fb)) % 256);
            idx = int'($urandom_range(0, 63));
            do_req(2, 32'(idx * 4), 4'hF, 4'h0, 32'd0, lat, rd, e, af);
            total++;
            if (lat < 2 || lat > 5 || lat !== exp_lat || rd !== model2[idx] || e !== 1'b0 || af !== 1'b0) begin
                bad++;
                $display("FAIL lfsr_read i=%0d lat=%0d rdata=%h err=%b after=%b required %0d/%h/0/0",
                         i, lat, rd, e, af, exp_lat, model2[idx]);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            model0[i] = $urandom;
            g_dut[0].dut.mem_q[i] = model0[i];
        end
        model0[16] = 32'hDEADBEEF;
        g_dut[0].dut.mem_q[16] = 32'hDEADBEEF;
        for (int i = 0; i < 16; i++) begin
            model1[i] = $urandom;
            g_dut[1].dut.mem_q[i] = model1[i];
        end
        for (int i = 0; i < 64; i++) begin
            model2[i] = $urandom;
            g_dut[2].dut.mem_q[i] = model2[i];
        end
        test_reset();
        test_directed();
        test_illegal();
        test_random();
        test_back_to_back();
        test_rst_wait();
        test_lfsr();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
